match_event_logger: RTL
=======================

MATCH_EVENT_LOGGER -- requirements
Module: match_event_logger

Interface
REQ-001 The block SHALL take parameter TS_W, default 16, as the timestamp width in bits.
REQ-002 The block SHALL take parameter DEPTH, default 4, as the event FIFO depth; it SHALL be a power of two and at least 2.
REQ-003 The block SHALL take parameter DROP_W, default 8, as the dropped-event counter width.
REQ-004 The block SHALL have port clk, input, 1 bit: clock, all logic on the rising edge.
REQ-005 The block SHALL have port rst_n, input, 1 bit: reset, asynchronous, active-low.
REQ-006 The block SHALL have port match, input, 1 bit: one-cycle detection pulse from the upstream sequence detector.
REQ-007 The block SHALL have port clr_ovf, input, 1 bit: synchronous clear of overflow and drop_cnt.
REQ-008 The block SHALL have port out_ready, input, 1 bit: consumer ready.
REQ-009 The block SHALL have port out_valid, output, 1 bit: head entry available.
REQ-010 The block SHALL have port out_data, output, TS_W bits: timestamp of the head entry.
REQ-011 The block SHALL have port out_count, output, $clog2(DEPTH)+1 bits: number of stored entries.
REQ-012 The block SHALL have port overflow, output, 1 bit: sticky flag, set when an event is dropped.
REQ-013 The block SHALL have port drop_cnt, output, DROP_W bits: saturating count of dropped events.

Function
REQ-014 The block SHALL keep a free-running counter ts_cnt of TS_W bits that increments on every clock edge and wraps from 2^TS_W-1 to 0.
REQ-015 When match=1 is sampled at an edge, the event timestamp SHALL be the value of ts_cnt before that edge's increment.
REQ-016 An event SHALL be pushed when match=1 and either the FIFO is not full or a pop occurs at the same edge.
REQ-017 A pop SHALL occur when out_valid=1 and out_ready=1 at the same edge.
REQ-018 out_valid SHALL equal (out_count != 0), and out_data SHALL be the oldest entry, held stable while out_valid=1 and out_ready=0.
REQ-019 Latency SHALL be one cycle: a push into an empty FIFO gives out_valid=1 in the cycle after the capturing edge; there is no combinational path from match to out_valid.
REQ-020 When pushing and popping at the same edge, out_count SHALL stay unchanged, including when the FIFO is full or holds one entry.
REQ-021 When match=1 and the FIFO is full with no pop, the event SHALL be dropped, overflow SHALL be set to 1, and drop_cnt SHALL increment, saturating at 2^DROP_W-1.
REQ-022 When clr_ovf=1 at an edge with no drop, overflow SHALL become 0 and drop_cnt SHALL become 0.
REQ-023 When clr_ovf=1 and a drop occur at the same edge, the drop SHALL win: overflow becomes 1 and drop_cnt becomes 1.
REQ-024 Read and write pointers SHALL wrap modulo DEPTH, and full/empty SHALL be derived from out_count.

Reset
REQ-025 While rst_n=0, ts_cnt, pointers, out_count, overflow and drop_cnt SHALL be 0, and out_valid SHALL be 0.
REQ-026 Reset asserted mid-operation SHALL discard all stored entries immediately, and out_data SHALL read 0 while reset is held.
REQ-027 After rst_n deasserts, the first active edge SHALL see ts_cnt=0.

Configuration
REQ-028 Defining MATCH_EVT_GAP_EN SHALL add output out_gap, TS_W bits, holding the head entry's timestamp minus the previous pushed event's timestamp, modulo 2^TS_W.
REQ-029 With MATCH_EVT_GAP_EN defined, the previous-timestamp register SHALL reset to 0, SHALL update on pushes only (dropped events excluded), and out_gap SHALL be stored per entry alongside out_data.
REQ-030 Without MATCH_EVT_GAP_EN, the out_gap port, gap storage and the previous-timestamp register SHALL NOT exist, and all other behaviour SHALL be identical.

Structure
REQ-031 Package match_evt_pkg SHALL hold the default constants TS_W_DEF=16, DEPTH_DEF=4 and DROP_W_DEF=8, and the entry struct typedef (timestamp, plus gap when MATCH_EVT_GAP_EN is defined).
REQ-032 Storage and pointer/count logic SHALL be one sub-module evt_fifo (synchronous push/pop, width-parameterised), instantiated once; the timestamp counter, drop logic and gap computation SHALL stay in the top level.

Verification
REQ-033 The bench SHALL check: reset release, match=1 at the edge with ts_cnt=5 -> next cycle out_valid=1, out_data=5, out_count=1, overflow=0.
REQ-034 The bench SHALL check: out_ready=0, five matches at ts 2,4,6,8,10 (DEPTH=4) -> entries 2,4,6,8 kept, 10 dropped, out_count=4, overflow=1, drop_cnt=1; draining then yields 2,4,6,8 in order.
REQ-035 The bench SHALL check: FIFO full, match=1 and out_ready=1 at the same edge -> head popped, new entry appended, out_count stays 4, overflow stays 0.
REQ-036 The bench SHALL check, with TS_W=4 and MATCH_EVT_GAP_EN defined: matches at ts 15 then ts 1 (wrapped) -> out_data 15 then 1; out_gap 15 then 2.
REQ-037 The bench SHALL check: overflow=1 and drop_cnt=3, then clr_ovf=1 at the same edge as a drop -> overflow=1, drop_cnt=1; the next clr_ovf alone -> overflow=0, drop_cnt=0.
REQ-038 The bench SHALL check: three entries stored, rst_n pulsed low between edges -> out_valid=0 and out_count=0 immediately, ts_cnt restarts at 0.

Source files
------------

// File: rtl/match_evt_pkg.sv
// Shared constants and the stored-entry layout for the match event logger.
// Defining MATCH_EVT_GAP_EN adds a per-entry gap field to the entry.
package match_evt_pkg;

    localparam int TS_W_DEF   = 16;
    localparam int DEPTH_DEF  = 4;
    localparam int DROP_W_DEF = 8;

    // Fields are sized for the default width; narrower builds zero-extend into them.
    typedef struct packed {
`ifdef MATCH_EVT_GAP_EN
        logic [TS_W_DEF-1:0] gap;
`endif
        logic [TS_W_DEF-1:0] ts;
    } evt_entry_t;

endpackage

// File: rtl/evt_fifo.sv
// Synchronous FIFO with power-of-two depth, wrapping pointers and an occupancy count.
// The caller guarantees that push is not asserted when full without a pop, and that pop is not asserted when empty.
module evt_fifo #(
    parameter  int W     = 16,
    parameter  int DEPTH = 4,
    localparam int AW    = $clog2(DEPTH),
    localparam int CW    = AW + 1
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          push_i,
    input  logic          pop_i,
    input  logic [W-1:0]  wdata_i,
    output logic [W-1:0]  rdata_o,
    output logic [CW-1:0] count_o
);

    logic [W-1:0]  mem_q [DEPTH];
    logic [AW-1:0] wr_ptr_q, rd_ptr_q;
    logic [CW-1:0] count_q, count_d;

    // NOTE: give every always_comb output a default first so no path leaves it unassigned (no latch).
    always_comb begin
        count_d = count_q;
        case ({push_i, pop_i})
            2'b10:   count_d = count_q + CW'(1);
            2'b01:   count_d = count_q - CW'(1);
            default: count_d = count_q;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so all registers update together at the edge.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (push_i) wr_ptr_q <= wr_ptr_q + AW'(1);
            if (pop_i)  rd_ptr_q <= rd_ptr_q + AW'(1);
            count_q <= count_d;
        end
    end

    // NOTE: storage is deliberately not reset; occupancy comes from count_q, so stale words are never exposed.
    always_ff @(posedge clk) begin
        if (push_i) mem_q[wr_ptr_q] <= wdata_i;
    end

    assign rdata_o = mem_q[rd_ptr_q];
    assign count_o = count_q;

endmodule

// File: rtl/match_event_logger.sv
// Timestamps match pulses into a small FIFO, counting events dropped when it is full.
// Defining MATCH_EVT_GAP_EN adds out_gap: the head timestamp minus the previously pushed timestamp.
module match_event_logger
    import match_evt_pkg::*;
#(
    parameter int TS_W   = TS_W_DEF,
    parameter int DEPTH  = DEPTH_DEF,
    parameter int DROP_W = DROP_W_DEF
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     match,
    input  logic                     clr_ovf,
    input  logic                     out_ready,
    output logic                     out_valid,
    output logic [TS_W-1:0]          out_data,
    output logic [$clog2(DEPTH):0]   out_count,
    output logic                     overflow,
    output logic [DROP_W-1:0]        drop_cnt
`ifdef MATCH_EVT_GAP_EN
   ,output logic [TS_W-1:0]          out_gap
`endif
);

    localparam int CW = $clog2(DEPTH) + 1;

    if (TS_W > TS_W_DEF || DEPTH < 2 || (DEPTH & (DEPTH - 1)) != 0) begin : g_param_check
        $error("match_event_logger: TS_W must not exceed TS_W_DEF and DEPTH must be a power of two >= 2");
    end

    logic [TS_W-1:0]   ts_q;
    logic              overflow_q, overflow_d;
    logic [DROP_W-1:0] drop_cnt_q, drop_cnt_d;
    logic [CW-1:0]     count;
    logic              full, pop, push, drop;
    evt_entry_t        wr_entry, rd_entry;

    assign out_valid = (count != '0);
    assign full      = (count == CW'(DEPTH));
    assign pop       = out_valid & out_ready;
    // A pop at the same edge frees a slot, so a full FIFO can still accept the event.
    assign push      = match & (~full | pop);
    assign drop      = match & full & ~pop;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) ts_q <= '0;
        else        ts_q <= ts_q + TS_W'(1);
    end

`ifdef MATCH_EVT_GAP_EN
    logic [TS_W-1:0] prev_ts_q;
    logic [TS_W-1:0] gap;

    assign gap = ts_q - prev_ts_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)    prev_ts_q <= '0;
        else if (push) prev_ts_q <= ts_q;
    end
`endif

    always_comb begin
        wr_entry    = '0;
        wr_entry.ts = TS_W_DEF'(ts_q);
`ifdef MATCH_EVT_GAP_EN
        wr_entry.gap = TS_W_DEF'(gap);
`endif
    end

    // A drop takes priority over a clear arriving at the same edge.
    always_comb begin
        overflow_d = overflow_q;
        drop_cnt_d = drop_cnt_q;
        if (drop) begin
            overflow_d = 1'b1;
            if (clr_ovf)                drop_cnt_d = DROP_W'(1);
            else if (drop_cnt_q != '1)  drop_cnt_d = drop_cnt_q + DROP_W'(1);
        end else if (clr_ovf) begin
            overflow_d = 1'b0;
            drop_cnt_d = '0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            overflow_q <= 1'b0;
            drop_cnt_q <= '0;
        end else begin
            overflow_q <= overflow_d;
            drop_cnt_q <= drop_cnt_d;
        end
    end

    evt_fifo #(
        .W     ($bits(evt_entry_t)),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk     (clk),
        .rst_n   (rst_n),
        .push_i  (push),
        .pop_i   (pop),
        .wdata_i (wr_entry),
        .rdata_o (rd_entry),
        .count_o (count)
    );

    assign out_data  = out_valid ? TS_W'(rd_entry.ts) : '0;
    assign out_count = count;
    assign overflow  = overflow_q;
    assign drop_cnt  = drop_cnt_q;
`ifdef MATCH_EVT_GAP_EN
    assign out_gap   = out_valid ? TS_W'(rd_entry.gap) : '0;
`endif

endmodule
